// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it LSB first
// with a start bit, optional parity bit and 1 or 2 stop bits on an idle-high line.
module uart_tx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int CLK_PER_BIT = 5208,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);
  // CLK_FREQ/BAUD_RATE only describe the intended rate; CLK_PER_BIT alone sets timing.
  localparam int CPB = (CLK_FREQ > 0 && BAUD_RATE > 0) ? CLK_PER_BIT : CLK_PER_BIT;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CPB - 2);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic          accept;
  logic          bit_end;
  logic          parity_bit;

  assign accept     = i_valid && o_ready;
  assign bit_end    = (cnt_reg == CNT_LAST);
  assign parity_bit = (^shift_reg) ^ PARITY_ODD[0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      o_tx      <= 1'b1;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      cnt_reg <= cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
          if (accept) begin
            shift_reg <= i_data;
            state_reg <= START;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
            o_ready   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= DATA;
            o_tx      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (idx_reg == 3'd7) begin
              idx_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                o_tx      <= parity_bit;
              end else begin
                state_reg <= STOP;
                o_tx      <= 1'b1;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
              o_tx    <= shift_reg[idx_reg + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= STOP;
            o_tx      <= 1'b1;
          end
        end
        STOP: begin
          // Raise done/ready one cycle early so both are high on the final stop cycle.
          if (cnt_reg == CNT_PRE && idx_reg == STOP_LAST) begin
            o_done  <= 1'b1;
            o_ready <= 1'b1;
          end
          if (bit_end) begin
            cnt_reg <= '0;
            if (idx_reg == STOP_LAST) begin
              idx_reg <= '0;
              if (accept) begin
                shift_reg <= i_data;
                state_reg <= START;
                o_tx      <= 1'b0;
                o_ready   <= 1'b0;
              end else begin
                state_reg <= IDLE;
                o_tx      <= 1'b1;
                o_busy    <= 1'b0;
                o_ready   <= 1'b1;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          idx_reg   <= '0;
          o_tx      <= 1'b1;
          o_busy    <= 1'b0;
          o_ready   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances at 4 clocks/bit covering 8N1, even/odd
// parity and two stop bits, with frame vectors, back-to-back, ignored input and reset.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ready [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    uart_tx #(
      .CLK_PER_BIT(CPB),
      .PARITY_EN  ((gi == 1 || gi == 2) ? 1 : 0),
      .PARITY_ODD ((gi == 2) ? 1 : 0),
      .STOP_BITS  ((gi == 3) ? 2 : 1)
    ) u_dut (
      .i_clk  (clk),
      .i_reset(reset),
      .i_data (data[gi]),
      .i_valid(valid[gi]),
      .o_ready(ready[gi]),
      .o_tx   (tx[gi]),
      .o_busy (busy[gi]),
      .o_done (done[gi])
    );
  end

  typedef struct {
    int         unit;
    logic [7:0] data;
    logic [11:0] bits;   // bit 0 = start bit, in line order
    int         nbits;
    string      name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic accept(input int u, input logic [7:0] d, input string nm);
    @(negedge clk);
    data[u]  = d;
    valid[u] = 1'b1;
    chk({nm, " ready_before_accept"}, 32'(ready[u]), 32'd1);
    @(posedge clk);
  endtask

  // mode 0: drop valid; 1: keep valid and present nd for a back-to-back accept;
  // 2: wiggle valid/data with 0x3C while busy, drop it on the final cycle.
  task automatic frame(input int u, input logic [11:0] bits, input int n,
                       input int mode, input logic [7:0] nd, input string nm);
    int last;
    last = n * CPB - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (mode == 0 && k == 0) valid[u] = 1'b0;
      if (mode == 1 && k == 0) data[u] = nd;
      if (mode == 2) begin
        data[u]  = 8'h3C;
        valid[u] = (k != last) && k[0];
      end
      chk($sformatf("%s tx k=%0d", nm, k), 32'(tx[u]), 32'(bits[k / CPB]));
      chk($sformatf("%s busy k=%0d", nm, k), 32'(busy[u]), 32'd1);
      chk($sformatf("%s done k=%0d", nm, k), 32'(done[u]), 32'(k == last));
      chk($sformatf("%s ready k=%0d", nm, k), 32'(ready[u]), 32'(k == last));
    end
    $display("[TB] frame %s unit %0d checked (%0d cycles)", nm, u, last + 1);
  endtask

  task automatic idle_check(input int u, input int cycles, input string nm);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk($sformatf("%s idle tx k=%0d", nm, k), 32'(tx[u]), 32'd1);
      chk($sformatf("%s idle busy k=%0d", nm, k), 32'(busy[u]), 32'd0);
      chk($sformatf("%s idle ready k=%0d", nm, k), 32'(ready[u]), 32'd1);
      chk($sformatf("%s idle done k=%0d", nm, k), 32'(done[u]), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 12'h34A, 10, "a5_8n1"};
    vecs[1] = '{0, 8'h00, 12'h200, 10, "00_8n1"};
    vecs[2] = '{0, 8'hFF, 12'h3FE, 10, "ff_8n1"};
    vecs[3] = '{0, 8'h55, 12'h2AA, 10, "55_8n1"};
    vecs[4] = '{1, 8'h07, 12'h60E, 11, "07_even"};
    vecs[5] = '{2, 8'h07, 12'h40E, 11, "07_odd"};
    vecs[6] = '{3, 8'h5A, 12'h6B4, 11, "5a_stop2"};

    reset = 1'b1;
    for (int u = 0; u < 4; u++) begin
      valid[u] = 1'b0;
      data[u]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("reset tx u%0d", u), 32'(tx[u]), 32'd1);
      chk($sformatf("reset ready u%0d", u), 32'(ready[u]), 32'd1);
      chk($sformatf("reset busy u%0d", u), 32'(busy[u]), 32'd0);
      chk($sformatf("reset done u%0d", u), 32'(done[u]), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].unit, vecs[i].data, vecs[i].name);
      frame(vecs[i].unit, vecs[i].bits, vecs[i].nbits, 0, 8'h00, vecs[i].name);
      idle_check(vecs[i].unit, 2, vecs[i].name);
    end

    // Back-to-back with two stop bits: second accept lands on the first o_done cycle.
    accept(3, 8'h00, "b2b_first");
    frame(3, 12'h600, 11, 1, 8'hFF, "b2b_first");
    frame(3, 12'h7FE, 11, 0, 8'h00, "b2b_second");
    idle_check(3, 2, "b2b");

    // Input activity while busy must not disturb the frame or start another.
    accept(0, 8'hA5, "ignore");
    frame(0, 12'h34A, 10, 2, 8'h00, "ignore");
    idle_check(0, 8, "ignore");

    // Reset during data bit 3 of 0xF0 (a 0 on the line), then a clean 0x81 frame.
    accept(0, 8'hF0, "rst_mid");
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) valid[0] = 1'b0;
    end
    chk("rst_mid tx before reset", 32'(tx[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid tx", 32'(tx[0]), 32'd1);
    chk("rst_mid ready", 32'(ready[0]), 32'd1);
    chk("rst_mid busy", 32'(busy[0]), 32'd0);
    chk("rst_mid done", 32'(done[0]), 32'd0);
    idle_check(0, 3, "rst_mid");
    accept(0, 8'h81, "after_rst");
    frame(0, 12'h302, 10, 0, 8'h00, "after_rst");
    idle_check(0, 2, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
